// File: rtl/counter_req_arbiter.sv
// Round-robin arbiter that shares one multi-counter among NREQ requesters.
// After reset or init_req it runs a CLEAR sweep, and it routes READ results back to the requester that asked.
module counter_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 8,
    parameter int DATA_W  = 8,
    parameter int NUM_IDS = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_req,
    output logic                   init_done,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [3*NREQ-1:0]      req_cmd,
    input  logic [ID_W*NREQ-1:0]   req_id,
    input  logic [DATA_W*NREQ-1:0] req_data,
    output logic                   ctr_valid,
    output logic [2:0]             ctr_cmd,
    output logic [ID_W-1:0]        ctr_id,
    output logic [DATA_W-1:0]      ctr_data,
    input  logic                   ctr_out_valid,
    input  logic [ID_W-1:0]        ctr_out_id,
    input  logic [DATA_W-1:0]      ctr_out_data,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DATA_W-1:0]      rsp_data
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int SWP_W = $clog2(NUM_IDS) + 1;
    localparam logic [SWP_W-1:0] LAST_ID = SWP_W'(NUM_IDS - 1);
    localparam logic [2:0] CMD_LOAD  = 3'd0;
    localparam logic [2:0] CMD_CLEAR = 3'd1;
    localparam logic [2:0] CMD_READ  = 3'd4;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state, state_next;
    logic [SWP_W-1:0]  sweep_cnt, sweep_next;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic              grant_any;
    int                cand;
    logic [2:0]        sel_cmd;
    logic [ID_W-1:0]   sel_id;
    logic [DATA_W-1:0] sel_data;
    logic              s1_read, s2_read;
    logic [IDX_W-1:0]  s1_idx, s2_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_next;
            sweep_cnt <= sweep_next;
        end
    end

    // init_req wins over sweep progress so a request mid-sweep restarts at id 0
    always_comb begin
        state_next = state;
        sweep_next = sweep_cnt;
        case (state)
            ST_INIT: begin
                if (init_req) begin
                    sweep_next = '0;
                end else begin
                    sweep_next = sweep_cnt + 1'b1;
                    if (sweep_cnt == LAST_ID) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    state_next = ST_INIT;
                    sweep_next = '0;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Search starts one past the last winner so every requester gets a turn
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        if (state == ST_RUN) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand     = (int'(rr_ptr) + k) % NREQ;
                cand_idx = IDX_W'(cand);
                if (!grant_any && req_valid[cand_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    assign req_ready = grant_any ? (NREQ'(1) << grant_idx) : '0;
    assign sel_cmd   = req_cmd[3*int'(grant_idx) +: 3];
    assign sel_id    = req_id[ID_W*int'(grant_idx) +: ID_W];
    assign sel_data  = req_data[DATA_W*int'(grant_idx) +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_valid <= 1'b0;
            ctr_cmd   <= CMD_LOAD;
            ctr_id    <= '0;
            ctr_data  <= '0;
            init_done <= 1'b0;
            rr_ptr    <= IDX_W'(NREQ - 1);
            s1_read   <= 1'b0;
            s1_idx    <= '0;
            s2_read   <= 1'b0;
            s2_idx    <= '0;
        end else begin
            // Idle cycles must park cmd on LOAD; the counter answers any READ cmd even when valid is low
            ctr_valid <= 1'b0;
            ctr_cmd   <= CMD_LOAD;
            init_done <= (state_next == ST_RUN);
            if (state == ST_INIT && !init_req) begin
                ctr_valid <= 1'b1;
                ctr_cmd   <= CMD_CLEAR;
                ctr_id    <= ID_W'(sweep_cnt);
                ctr_data  <= '0;
            end else if (grant_any) begin
                ctr_valid <= 1'b1;
                ctr_cmd   <= sel_cmd;
                ctr_id    <= sel_id;
                ctr_data  <= sel_data;
                rr_ptr    <= grant_idx;
            end
            s1_read <= grant_any && (sel_cmd == CMD_READ);
            s1_idx  <= grant_idx;
            s2_read <= s1_read;
            s2_idx  <= s1_idx;
        end
    end

    assign rsp_valid = (ctr_out_valid && s2_read) ? (NREQ'(1) << s2_idx) : '0;
    assign rsp_id    = ctr_out_id;
    assign rsp_data  = ctr_out_data;

endmodule

// File: tb/tb_counter_req_arbiter.sv
// Scoreboard bench for counter_req_arbiter with a behavioural multi-counter attached to the ctr_* port.
// Expected grants, counter commands and READ responses are queued at handshake time and compared when due.
module tb_counter_req_arbiter;

    localparam int NREQ    = 4;
    localparam int ID_W    = 8;
    localparam int DATA_W  = 8;
    localparam int NUM_IDS = 256;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   init_req;
    logic                   init_done;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [3*NREQ-1:0]      req_cmd;
    logic [ID_W*NREQ-1:0]   req_id;
    logic [DATA_W*NREQ-1:0] req_data;
    logic                   ctr_valid;
    logic [2:0]             ctr_cmd;
    logic [ID_W-1:0]        ctr_id;
    logic [DATA_W-1:0]      ctr_data;
    logic                   ctr_out_valid;
    logic [ID_W-1:0]        ctr_out_id;
    logic [DATA_W-1:0]      ctr_out_data;
    logic [NREQ-1:0]        rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [DATA_W-1:0]      rsp_data;

    typedef struct {
        int                cyc;
        logic [2:0]        cmd;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } ctr_exp_t;

    typedef struct {
        int                cyc;
        logic [NREQ-1:0]   onehot;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } rsp_exp_t;

    ctr_exp_t          ctr_q[$];
    rsp_exp_t          rsp_q[$];
    logic [DATA_W-1:0] ref_mem [NUM_IDS];
    logic [DATA_W-1:0] cmem [NUM_IDS];
    int                checks = 0;
    int                failures = 0;
    int                cyc = 0;
    int                exp_rr = NREQ - 1;
    bit                run_grant = 1'b0;
    bit                idle_chk = 1'b0;

    counter_req_arbiter #(
        .NREQ(NREQ), .ID_W(ID_W), .DATA_W(DATA_W), .NUM_IDS(NUM_IDS)
    ) dut (
        .clk(clk), .rst(rst), .init_req(init_req), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_id(req_id), .req_data(req_data),
        .ctr_valid(ctr_valid), .ctr_cmd(ctr_cmd), .ctr_id(ctr_id), .ctr_data(ctr_data),
        .ctr_out_valid(ctr_out_valid), .ctr_out_id(ctr_out_id), .ctr_out_data(ctr_out_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    // Counter model: one-cycle READ latency, answers any READ cmd regardless of valid
    always @(posedge clk) begin
        ctr_out_valid <= (ctr_cmd == 3'd4);
        ctr_out_id    <= ctr_id;
        ctr_out_data  <= cmem[ctr_id];
        if (ctr_valid === 1'b1) begin
            case (ctr_cmd)
                3'd0: cmem[ctr_id] <= ctr_data;
                3'd1: cmem[ctr_id] <= '0;
                3'd2: cmem[ctr_id] <= cmem[ctr_id] + 1'b1;
                3'd3: cmem[ctr_id] <= cmem[ctr_id] - 1'b1;
                default: ;
            endcase
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic setReq(input int r, input logic [2:0] c, input logic [ID_W-1:0] i, input logic [DATA_W-1:0] d);
        req_cmd[3*r +: 3]           = c;
        req_id[ID_W*r +: ID_W]      = i;
        req_data[DATA_W*r +: DATA_W] = d;
    endtask

    // Compares everything due this cycle, then models the arbitration decision and queues its effects
    task automatic sampleCycle();
        ctr_exp_t        ce;
        rsp_exp_t        re;
        logic [NREQ-1:0] exp_ready;
        int              g;
        int              c;
        if (ctr_q.size() > 0 && ctr_q[0].cyc == cyc) begin
            ce = ctr_q.pop_front();
            checkOutput("ctr_valid", ctr_valid, 1);
            checkOutput("ctr_cmd", ctr_cmd, ce.cmd);
            checkOutput("ctr_id", ctr_id, ce.id);
            checkOutput("ctr_data", ctr_data, ce.data);
        end else if (idle_chk) begin
            checkOutput("idle_ctr_valid", ctr_valid, 0);
            checkOutput("idle_ctr_cmd", ctr_cmd, 0);
        end
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
            re = rsp_q.pop_front();
            checkOutput("rsp_valid", rsp_valid, re.onehot);
            checkOutput("rsp_id", rsp_id, re.id);
            checkOutput("rsp_data", rsp_data, re.data);
        end else begin
            checkOutput("rsp_quiet", rsp_valid, 0);
        end
        if (run_grant) begin
            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                c = (exp_rr + k) % NREQ;
                if (g < 0 && req_valid[c]) g = c;
            end
            exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
            checkOutput("req_ready", req_ready, exp_ready);
            if (g >= 0) begin
                exp_rr  = g;
                ce.cyc  = cyc + 1;
                ce.cmd  = req_cmd[3*g +: 3];
                ce.id   = req_id[ID_W*g +: ID_W];
                ce.data = req_data[DATA_W*g +: DATA_W];
                ctr_q.push_back(ce);
                case (ce.cmd)
                    3'd0: ref_mem[ce.id] = ce.data;
                    3'd1: ref_mem[ce.id] = '0;
                    3'd2: ref_mem[ce.id] = ref_mem[ce.id] + 1'b1;
                    3'd3: ref_mem[ce.id] = ref_mem[ce.id] - 1'b1;
                    default: begin
                        re.cyc    = cyc + 2;
                        re.onehot = exp_ready;
                        re.id     = ce.id;
                        re.data   = ref_mem[ce.id];
                        rsp_q.push_back(re);
                    end
                endcase
            end
        end else begin
            checkOutput("ready_blocked", req_ready, 0);
        end
    endtask

    task automatic tickSample();
        @(negedge clk);
        cyc++;
        sampleCycle();
    endtask

    task automatic tickAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ini);
        req_valid = valid;
        init_req  = ini;
        tickSample();
        tickAdvance();
    endtask

    // Waits for the first CLEAR, then follows the whole sweep; grants resume on its final cycle
    task automatic runSweep();
        bit found = 1'b0;
        init_req  = 1'b0;
        run_grant = 1'b0;
        idle_chk  = 1'b0;
        for (int w = 0; w < 6 && !found; w++) begin
            tickSample();
            if (ctr_valid === 1'b1 && ctr_cmd === 3'd1) begin
                found = 1'b1;
            end else begin
                checkOutput("init_done_low", init_done, 0);
                if (w == 5) checkOutput("sweep_start", ctr_valid, 1);
                tickAdvance();
            end
        end
        if (found) begin
            for (int i = 0; i < NUM_IDS; i++) ref_mem[i] = '0;
            for (int i = 0; i < NUM_IDS; i++) begin
                if (i > 0) begin
                    tickAdvance();
                    run_grant = (i == NUM_IDS - 1);
                    tickSample();
                end
                checkOutput("sweep_valid", ctr_valid, 1);
                checkOutput("sweep_cmd", ctr_cmd, 1);
                checkOutput("sweep_id", ctr_id, i);
                checkOutput("sweep_done", init_done, (i == NUM_IDS - 1) ? 1 : 0);
            end
            tickAdvance();
        end
        run_grant = 1'b1;
        idle_chk  = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        init_req  = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        req_id    = '0;
        req_data  = '0;
        tickAdvance();
        tickAdvance();
        rst = 1'b0;
        tickSample();
        checkOutput("reset_ctr_valid", ctr_valid, 0);
        checkOutput("reset_ctr_cmd", ctr_cmd, 0);
        checkOutput("reset_ctr_id", ctr_id, 0);
        checkOutput("reset_ctr_data", ctr_data, 0);
        checkOutput("reset_init_done", init_done, 0);
        tickAdvance();
        runSweep();

        $display("[TB] idle cycles in RUN");
        for (int n = 0; n < 3; n++) applyStimulus('0, 1'b0);

        $display("[TB] all requesters valid, round-robin order");
        for (int r = 0; r < NREQ; r++) setReq(r, 3'd2, ID_W'(20 + r), '0);
        for (int n = 0; n < 8; n++) applyStimulus('1, 1'b0);
        for (int n = 0; n < 2; n++) applyStimulus('0, 1'b0);

        $display("[TB] LOAD then READ from requester 1");
        setReq(1, 3'd0, 8'd5, 8'h7F);
        applyStimulus(4'b0010, 1'b0);
        setReq(1, 3'd4, 8'd5, 8'h00);
        applyStimulus(4'b0010, 1'b0);
        for (int n = 0; n < 3; n++) applyStimulus('0, 1'b0);

        $display("[TB] INC from requester 0 then READ from requester 2");
        setReq(0, 3'd2, 8'd9, 8'h00);
        applyStimulus(4'b0001, 1'b0);
        setReq(2, 3'd4, 8'd9, 8'h00);
        applyStimulus(4'b0100, 1'b0);
        for (int n = 0; n < 3; n++) applyStimulus('0, 1'b0);

        $display("[TB] random traffic");
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < NREQ; r++)
                setReq(r, 3'($urandom_range(0, 4)), ID_W'($urandom_range(0, 15)), DATA_W'($urandom));
            applyStimulus(NREQ'($urandom), 1'b0);
        end
        for (int n = 0; n < 3; n++) applyStimulus('0, 1'b0);

        $display("[TB] init_req with a READ in flight");
        setReq(3, 3'd4, 8'd5, 8'h00);
        applyStimulus(4'b1000, 1'b0);
        applyStimulus('0, 1'b1);
        for (int r = 0; r < NREQ; r++) setReq(r, 3'd4, ID_W'(30 + r), '0);
        req_valid = '1;
        runSweep();
        for (int n = 0; n < 4; n++) applyStimulus('1, 1'b0);
        for (int n = 0; n < 4; n++) applyStimulus('0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
